// File: rtl/icache_tag_lookup_nway.sv
// icache_tag_lookup_nway
//   N-way set-associative instruction-cache tag lookup. One single-port tag
//   RAM holds every way of a set in a single word ({valid, tag} per way, way0
//   in the LSBs). After reset the whole RAM is swept to zero, then requests
//   are accepted. Each request takes a one-cycle read followed by an S1
//   compare stage. S1 reports hit/victim way plus an MSHR conflict flag, and
//   may schedule one write-back of the modified set through a one-entry write
//   buffer. Victims are chosen by a per-set tree-PLRU.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   req_vld/req_rdy/req_op/req_index/req_tag/req_txnid   lookup request
//   stall                              downstream back-pressure (blocks accept)
//   ram_en/ram_wr_en/ram_addr/ram_din/ram_dout           tag RAM port
//   rsp_vld/rsp_hit/rsp_way/rsp_conflict/rsp_txnid       S1 result
//   mshr_vld/mshr_index/mshr_way       live MSHR targets (flat vectors)
//   mshr_rel_vld/mshr_rel_idx          entry releasing this cycle
//   init_done                          invalidate sweep finished
//
// FSM states
//   state   | meaning
//   ST_INIT | writing zeros to tag RAM set cnt_q, no requests accepted
//   ST_RUN  | normal lookup operation
module icache_tag_lookup_nway #(
  parameter int WAYS     = 4,
  parameter int SETS     = 64,
  parameter int TAG_W    = 20,
  parameter int MSHR_NUM = 8,
  parameter int TXN_W    = 4,
  localparam int IDX_W   = $clog2(SETS),
  localparam int WAY_W   = $clog2(WAYS),
  localparam int ENT_W   = TAG_W + 1,
  localparam int MID_W   = $clog2(MSHR_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [1:0]               req_op,
  input  logic [IDX_W-1:0]         req_index,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [TXN_W-1:0]         req_txnid,
  input  logic                     stall,
  output logic                     ram_en,
  output logic                     ram_wr_en,
  output logic [IDX_W-1:0]         ram_addr,
  output logic [WAYS*ENT_W-1:0]    ram_din,
  input  logic [WAYS*ENT_W-1:0]    ram_dout,
  output logic                     rsp_vld,
  output logic                     rsp_hit,
  output logic [WAY_W-1:0]         rsp_way,
  output logic                     rsp_conflict,
  output logic [TXN_W-1:0]         rsp_txnid,
  input  logic [MSHR_NUM-1:0]      mshr_vld,
  input  logic [MSHR_NUM*IDX_W-1:0] mshr_index,
  input  logic [MSHR_NUM*WAY_W-1:0] mshr_way,
  input  logic                     mshr_rel_vld,
  input  logic [MID_W-1:0]         mshr_rel_idx,
  output logic                     init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  init_done_q;

  logic [WAYS-2:0]       plru_q [SETS];

  logic                  s1_vld_q;
  logic [1:0]            s1_op_q;
  logic [IDX_W-1:0]      s1_index_q;
  logic [TAG_W-1:0]      s1_tag_q;
  logic [TXN_W-1:0]      s1_txnid_q;

  logic                  wbuf_vld_q;
  logic [IDX_W-1:0]      wbuf_index_q;
  logic [WAYS*ENT_W-1:0] wbuf_data_q;

  logic                  fire;
  logic                  init_wr;
  logic [WAYS*ENT_W-1:0] set_data;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_any;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      sel_way;
  logic                  op_alloc;
  logic                  op_inval;
  logic                  plru_upd;
  logic                  wbuf_load;
  logic [WAYS*ENT_W-1:0] wbuf_next;
  logic                  conflict;

  // Heap-ordered tree: node n (1-based) lives in bit n-1, children 2n / 2n+1.
  // A 0 bit steers the victim search to the left child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 1;
    for (int lvl = 0; lvl < WAY_W; lvl++)
      node = 2 * node + int'(bits[node-1]);
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] b;
    int              node;
    logic            d;
    b    = bits;
    node = 1;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      d          = way[WAY_W-1-lvl];
      b[node-1]  = ~d;
      node       = 2 * node + int'(d);
    end
    return b;
  endfunction

  // Reset gating keeps the RAM port quiet while rst_n is held low even
  // though the FSM already sits in ST_INIT.
  assign init_wr = rst_n & (state_q == ST_INIT);
  assign req_rdy = (state_q == ST_RUN) & ~stall & ~wbuf_vld_q;
  assign fire    = req_vld & req_rdy;

  assign ram_en    = init_wr | wbuf_vld_q | fire;
  assign ram_wr_en = init_wr | wbuf_vld_q;
  assign ram_addr  = init_wr    ? cnt_q :
                     wbuf_vld_q ? wbuf_index_q : req_index;
  assign ram_din   = wbuf_vld_q ? wbuf_data_q : '0;

  always_comb begin
    logic [ENT_W-1:0] ent;
    ent      = '0;
    // A request accepted in the cycle its predecessor filled the write
    // buffer read the RAM before that write landed; use the buffer instead.
    set_data = (wbuf_vld_q && (wbuf_index_q == s1_index_q)) ? wbuf_data_q : ram_dout;
    hit_any  = 1'b0;
    hit_way  = '0;
    inv_any  = 1'b0;
    inv_way  = '0;
    // Walk high to low so the lowest matching way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      ent = set_data[w*ENT_W +: ENT_W];
      if (ent[TAG_W] && (ent[TAG_W-1:0] == s1_tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!ent[TAG_W]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end

    sel_way = hit_any ? hit_way :
              inv_any ? inv_way : plru_victim(plru_q[s1_index_q]);

    // Reserved op 3 decodes as neither, i.e. a plain lookup.
    op_alloc  = (s1_op_q == 2'd1);
    op_inval  = (s1_op_q == 2'd2);
    plru_upd  = s1_vld_q & ((hit_any & ~op_inval) | (~hit_any & op_alloc));
    wbuf_load = s1_vld_q & ((hit_any & op_inval) | (~hit_any & op_alloc));

    // Allocate writes {1,tag}; invalidate rewrites the hit way (tag equal to
    // the request tag) with valid cleared.
    wbuf_next = set_data;
    for (int w = 0; w < WAYS; w++)
      if (WAY_W'(w) == sel_way)
        wbuf_next[w*ENT_W +: ENT_W] = {op_alloc, s1_tag_q};

    conflict = 1'b0;
    for (int i = 0; i < MSHR_NUM; i++)
      if (mshr_vld[i] &&
          (mshr_index[i*IDX_W +: IDX_W] == s1_index_q) &&
          (mshr_way[i*WAY_W +: WAY_W] == sel_way) &&
          !(mshr_rel_vld && (mshr_rel_idx == MID_W'(i))))
        conflict = 1'b1;
  end

  assign rsp_vld      = s1_vld_q;
  assign rsp_hit      = s1_vld_q & hit_any;
  assign rsp_way      = s1_vld_q ? sel_way : '0;
  assign rsp_conflict = s1_vld_q & conflict;
  assign rsp_txnid    = s1_txnid_q;
  assign init_done    = init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == IDX_W'(SETS - 1)) begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_upd) begin
      plru_q[s1_index_q] <= plru_touch(plru_q[s1_index_q], sel_way);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_op_q    <= 2'd0;
      s1_index_q <= '0;
      s1_tag_q   <= '0;
      s1_txnid_q <= '0;
    end else begin
      s1_vld_q <= fire;
      if (fire) begin
        s1_op_q    <= req_op;
        s1_index_q <= req_index;
        s1_tag_q   <= req_tag;
        s1_txnid_q <= req_txnid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_vld_q   <= 1'b0;
      wbuf_index_q <= '0;
      wbuf_data_q  <= '0;
    end else begin
      wbuf_vld_q <= wbuf_load;
      if (wbuf_load) begin
        wbuf_index_q <= s1_index_q;
        wbuf_data_q  <= wbuf_next;
      end
    end
  end

endmodule
